// File: rtl/wb_arbiter_pkg.sv
// Shared globals for the Wishbone interconnect: arbiter state encoding,
// default master count, address-map bases and a pointer-width helper.
package wb_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    localparam int WB_DEFAULT_N_MASTERS = 3;

    // Existing address map of the slave segment behind the arbiter.
    localparam logic [15:0] WB_MAP_ROM_BASE = 16'h0000;
    localparam logic [15:0] WB_MAP_RAM_BASE = 16'h4000;
    localparam logic [15:0] WB_MAP_IO_BASE  = 16'hF000;

    // Width of an index into n masters, never below one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Round-robin picker: returns the first requester found when searching
// upward from ptr and wrapping from N-1 back to 0. Purely combinational.
module wb_rr_pick
    import wb_arbiter_pkg::*;
#(
    parameter int N  = WB_DEFAULT_N_MASTERS,
    parameter int PW = ptr_width(WB_DEFAULT_N_MASTERS)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick
);

    localparam logic [PW:0] N_W = (PW + 1)'(N);

    logic [PW:0]   sum_s;
    logic [PW:0]   wrap_s;
    logic [PW-1:0] idx_s;
    logic          found_s;

    // Walk the masters in priority order starting at ptr; first hit wins.
    always_comb begin
        pick    = '0;
        found_s = 1'b0;
        sum_s   = '0;
        wrap_s  = '0;
        idx_s   = '0;
        for (int i = 0; i < N; i++) begin
            sum_s       = {1'b0, ptr} + (PW + 1)'(i);
            wrap_s      = (sum_s >= N_W) ? (sum_s - N_W) : sum_s;
            idx_s       = wrap_s[PW-1:0];
            pick[idx_s] = req[idx_s] & ~found_s;
            found_s     = found_s | req[idx_s];
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Wishbone multi-master arbiter: one owner at a time, round-robin choice
// in IDLE, registered one-hot grant, one IDLE cycle between owners and
// combinational muxing of the owner's bus onto the slave side.
// Optional stalled-strobe timeout is built when WB_ARBITER_TIMEOUT_EN is
// defined; otherwise m_err_o is tied low and a grant is held indefinitely.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int N_MASTERS      = WB_DEFAULT_N_MASTERS,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [N_MASTERS-1:0]            m_cyc_i,
    input  logic [N_MASTERS-1:0]            m_stb_i,
    input  logic [N_MASTERS-1:0]            m_we_i,
    input  logic [N_MASTERS-1:0]            m_sel_i,
    input  logic [N_MASTERS*ADDRESS_WIDTH-1:0] m_adr_i,
    input  logic [N_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    input  logic [N_MASTERS*3-1:0]          m_cti_i,
    output logic [N_MASTERS-1:0]            m_ack_o,
    output logic [N_MASTERS-1:0]            m_err_o,
    output logic [DATA_WIDTH-1:0]           m_dat_o,
    output logic [N_MASTERS-1:0]            m_busy_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    output logic                            s_sel_o,
    output logic [ADDRESS_WIDTH-1:0]        s_adr_o,
    output logic [DATA_WIDTH-1:0]           s_dat_o,
    output logic [2:0]                      s_cti_o,
    input  logic [DATA_WIDTH-1:0]           s_dat_i,
    input  logic                            s_ack_i,
    output logic [N_MASTERS-1:0]            grant_o
);

    localparam int PW = ptr_width(N_MASTERS);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_MASTERS - 1);

    arb_state_e           state_r;
    logic [N_MASTERS-1:0] grant_r;
    logic [PW-1:0]        rr_ptr_r;
    logic [N_MASTERS-1:0] pick_s;
    logic [N_MASTERS-1:0] sel_s;
    logic [N_MASTERS-1:0] err_s;
    logic [PW-1:0]        owner_idx_s;
    logic [PW-1:0]        next_ptr_s;
    logic                 owned_s;
    logic                 owner_cyc_s;
    logic                 tmo_s;

    wb_rr_pick #(
        .N  (N_MASTERS),
        .PW (PW)
    ) u_pick (
        .req  (m_cyc_i),
        .ptr  (rr_ptr_r),
        .pick (pick_s)
    );

    // Reset forces the slave side quiet even before the grant register clears.
    assign owned_s     = (state_r == ST_OWNED) && !rst_i;
    assign sel_s       = grant_r & {N_MASTERS{owned_s}};
    assign owner_cyc_s = |(m_cyc_i & grant_r);
    assign next_ptr_s  = (owner_idx_s == LAST_IDX) ? '0 : (owner_idx_s + PW'(1));

    // One-hot grant to binary owner index (OR of masked indices).
    always_comb begin
        owner_idx_s = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            owner_idx_s = owner_idx_s | (PW'(i) & {PW{grant_r[i]}});
        end
    end

    // AND-OR mux of the owner's bus; a strobe without cyc is ignored.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_cti_o = 3'b000;
        for (int i = 0; i < N_MASTERS; i++) begin
            s_cyc_o = s_cyc_o | (sel_s[i] & m_cyc_i[i]);
            s_stb_o = s_stb_o | (sel_s[i] & m_cyc_i[i] & m_stb_i[i]);
            s_we_o  = s_we_o  | (sel_s[i] & m_we_i[i]);
            s_sel_o = s_sel_o | (sel_s[i] & m_sel_i[i]);
            s_adr_o = s_adr_o | (m_adr_i[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] & {ADDRESS_WIDTH{sel_s[i]}});
            s_dat_o = s_dat_o | (m_dat_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_s[i]}});
            s_cti_o = s_cti_o | (m_cti_i[i*3 +: 3] & {3{sel_s[i]}});
        end
    end

    assign m_ack_o  = sel_s & {N_MASTERS{s_ack_i}};
    assign m_busy_o = {N_MASTERS{s_cyc_o}} & ~grant_r;
    assign m_err_o  = err_s & {N_MASTERS{~rst_i}};
    assign m_dat_o  = s_dat_i;
    assign grant_o  = grant_r;

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0]        tmo_cnt_r;
    logic [N_MASTERS-1:0] err_r;

    assign tmo_s = (tmo_cnt_r == TMO_LIMIT);
    assign err_s = err_r;

    // Count stalled strobes of the owner; flag the owner on the limit-th stall.
    always_ff @(posedge clk_i) begin
        err_r <= '0;
        if (rst_i) begin
            tmo_cnt_r <= '0;
        end else if (!owned_s || !owner_cyc_s || tmo_s) begin
            tmo_cnt_r <= '0;
        end else if (s_ack_i) begin
            tmo_cnt_r <= '0;
        end else if (s_stb_o) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
            if (tmo_cnt_r == (TMO_LIMIT - TW'(1))) begin
                err_r <= grant_r;
            end
        end
    end
`else
    assign tmo_s = 1'b0;
    assign err_s = '0;
`endif

    // Arbitration FSM: grant from IDLE, release on owner drop or timeout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            grant_r  <= '0;
            rr_ptr_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|m_cyc_i) begin
                        state_r <= ST_OWNED;
                        grant_r <= pick_s;
                    end
                end
                ST_OWNED: begin
                    if (!owner_cyc_s || tmo_s) begin
                        state_r  <= ST_IDLE;
                        grant_r  <= '0;
                        rr_ptr_r <= next_ptr_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter with a behavioural owner/pointer model.
module tb_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 8;
`ifdef WB_ARBITER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
    localparam int TMO    = 8;
`else
    localparam bit TMO_EN = 1'b0;
    localparam int TMO    = 255;
`endif

    logic clk_i = 1'b0;
    logic rst_i;
    logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i, m_sel_i;
    logic [N*AW-1:0] m_adr_i;
    logic [N*DW-1:0] m_dat_i;
    logic [N*3-1:0]  m_cti_i;
    logic [N-1:0]    m_ack_o, m_err_o, m_busy_o, grant_o;
    logic [DW-1:0]   m_dat_o, s_dat_o, s_dat_i;
    logic            s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_ack_i;
    logic [AW-1:0]   s_adr_o;
    logic [2:0]      s_cti_o;

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 = bus free), round-robin pointer, stall count.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    logic [N-1:0]  exp_grant, exp_ack, exp_err, exp_busy;
    logic          exp_cyc, exp_stb, exp_we, exp_sel;
    logic [AW-1:0] exp_adr;
    logic [DW-1:0] exp_dat;
    logic [2:0]    exp_cti;

    logic [N-1:0] seq_q[$];
    logic [N-1:0] exp_seq [0:6] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};

    wb_arbiter #(
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .N_MASTERS      (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .m_cyc_i  (m_cyc_i),
        .m_stb_i  (m_stb_i),
        .m_we_i   (m_we_i),
        .m_sel_i  (m_sel_i),
        .m_adr_i  (m_adr_i),
        .m_dat_i  (m_dat_i),
        .m_cti_i  (m_cti_i),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .m_dat_o  (m_dat_o),
        .m_busy_o (m_busy_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_cti_o  (s_cti_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .grant_o  (grant_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic model_outputs();
        exp_grant = '0;
        if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
        exp_cyc = 1'b0; exp_stb = 1'b0; exp_we = 1'b0; exp_sel = 1'b0;
        exp_adr = '0; exp_dat = '0; exp_cti = 3'b000;
        exp_ack = '0; exp_busy = '0; exp_err = '0;
        if (!rst_i && m_owner >= 0) begin
            exp_cyc  = m_cyc_i[m_owner];
            exp_stb  = m_cyc_i[m_owner] & m_stb_i[m_owner];
            exp_we   = m_we_i[m_owner];
            exp_sel  = m_sel_i[m_owner];
            exp_adr  = m_adr_i[m_owner*AW +: AW];
            exp_dat  = m_dat_i[m_owner*DW +: DW];
            exp_cti  = m_cti_i[m_owner*3 +: 3];
            exp_ack  = s_ack_i ? exp_grant : '0;
            exp_busy = exp_cyc ? ~exp_grant : '0;
            exp_err  = (TMO_EN && m_cnt >= TMO) ? exp_grant : '0;
        end
    endtask

    task automatic model_clock();
        if (rst_i) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (m_owner < 0 && m_cyc_i[j]) m_owner = j;
            end
            m_cnt = 0;
        end else if (!m_cyc_i[m_owner] || (TMO_EN && m_cnt >= TMO)) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1; m_cnt = 0;
        end else if (s_ack_i) begin
            m_cnt = 0;
        end else if (m_stb_i[m_owner]) begin
            m_cnt++;
        end
    endtask

    task automatic advance();
        model_clock();
        @(posedge clk_i);
        #1;
    endtask

    task automatic step();
        @(negedge clk_i);
        advance();
    endtask

    task automatic rand_buses();
        for (int i = 0; i < N; i++) begin
            m_adr_i[i*AW +: AW] = AW'($urandom());
            m_dat_i[i*DW +: DW] = DW'($urandom());
            m_cti_i[i*3 +: 3]   = 3'($urandom());
        end
        m_we_i  = N'($urandom());
        m_sel_i = N'($urandom());
        s_dat_i = DW'($urandom());
    endtask

    task automatic test_reset();
        rst_i = 1'b1; m_cyc_i = 3'b111; m_stb_i = 3'b111; s_ack_i = 1'b1;
        rand_buses();
        step(); step();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL rst_grant: got %b expected 000", grant_o); end
            checks++; if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o} !== 4'b0000) begin errors++; $display("FAIL rst_s_ctrl: got %b expected 0000", {s_cyc_o, s_stb_o, s_we_o, s_sel_o}); end
            checks++; if ({s_adr_o, s_dat_o, s_cti_o} !== 27'd0) begin errors++; $display("FAIL rst_s_bus: got %h expected 0", {s_adr_o, s_dat_o, s_cti_o}); end
            checks++; if ({m_ack_o, m_err_o, m_busy_o} !== 9'd0) begin errors++; $display("FAIL rst_m_out: got %b expected 0", {m_ack_o, m_err_o, m_busy_o}); end
            advance();
        end
        rst_i = 1'b0; m_cyc_i = '0; m_stb_i = '0; s_ack_i = 1'b0;
        step();
    endtask

    task automatic test_single();
        rand_buses();
        m_cyc_i = 3'b010; m_stb_i = 3'b010;
        @(negedge clk_i); model_outputs();
        checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL single_latency: got %b expected 000", grant_o); end
        advance();
        s_ack_i = 1'b1;
        @(negedge clk_i); model_outputs();
        checks++; if (grant_o !== 3'b010) begin errors++; $display("FAIL single_grant: got %b expected 010", grant_o); end
        checks++; if (s_adr_o !== m_adr_i[AW +: AW]) begin errors++; $display("FAIL single_adr: got %h expected %h", s_adr_o, m_adr_i[AW +: AW]); end
        checks++; if (m_ack_o !== 3'b010) begin errors++; $display("FAIL single_ack: got %b expected 010", m_ack_o); end
        advance();
        m_cyc_i = '0; m_stb_i = '0; s_ack_i = 1'b0;
        @(negedge clk_i); model_outputs();
        checks++; if (s_cyc_o !== 1'b0 || m_busy_o !== 3'b000) begin errors++; $display("FAIL single_drop: got cyc %b busy %b expected 0 000", s_cyc_o, m_busy_o); end
        advance();
        step();
    endtask

    task automatic test_all_request();
        int held [N];
        bit done [N];
        rst_i = 1'b1; step(); rst_i = 1'b0;
        seq_q.delete();
        for (int i = 0; i < N; i++) begin held[i] = 0; done[i] = 1'b0; end
        for (int c = 0; c < 14; c++) begin
            for (int i = 0; i < N; i++) m_cyc_i[i] = !done[i];
            m_stb_i = m_cyc_i;
            @(negedge clk_i); model_outputs();
            checks++; if (grant_o !== exp_grant) begin errors++; $display("FAIL rr_grant: got %b expected %b", grant_o, exp_grant); end
            if (seq_q.size() == 0 || seq_q[$] != grant_o) seq_q.push_back(grant_o);
            if (m_owner >= 0) begin
                held[m_owner]++;
                if (held[m_owner] >= 2) done[m_owner] = 1'b1;
            end
            advance();
        end
        checks++;
        if (seq_q.size() != 7) begin
            errors++; $display("FAIL rr_order_len: got %0d phases expected 7", seq_q.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++; if (seq_q[i] !== exp_seq[i]) begin errors++; $display("FAIL rr_order: phase %0d got %b expected %b", i, seq_q[i], exp_seq[i]); end
            end
        end
        m_cyc_i = '0; m_stb_i = '0;
        step();
    endtask

    task automatic test_busy();
        m_cyc_i = 3'b100; m_stb_i = 3'b100;
        step();
        m_cyc_i = 3'b101; m_stb_i = 3'b101;
        for (int c = 0; c < 4; c++) begin
            s_ack_i = 1'($urandom());
            @(negedge clk_i); model_outputs();
            checks++; if (m_busy_o !== 3'b011) begin errors++; $display("FAIL busy_vec: got %b expected 011", m_busy_o); end
            checks++; if (grant_o !== 3'b100) begin errors++; $display("FAIL busy_hold: got %b expected 100", grant_o); end
            checks++; if (m_ack_o !== exp_ack) begin errors++; $display("FAIL busy_ack: got %b expected %b", m_ack_o, exp_ack); end
            advance();
        end
        s_ack_i = 1'b0; m_cyc_i = 3'b001; m_stb_i = 3'b001;
        step();
        @(negedge clk_i); model_outputs();
        checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL busy_gap: got %b expected 000", grant_o); end
        advance();
        @(negedge clk_i); model_outputs();
        checks++; if (grant_o !== 3'b001) begin errors++; $display("FAIL busy_next: got %b expected 001", grant_o); end
        advance();
        m_cyc_i = '0; m_stb_i = '0;
        step(); step();
    endtask

    task automatic test_burst();
        int o, g, acks, c;
        o = int'($urandom_range(N - 1, 0));
        g = 0; acks = 0; c = 0;
        rand_buses();
        for (int i = 0; i < N; i++) m_cti_i[i*3 +: 3] = 3'b010;
        while (acks < 4 && c < 30) begin
            if (m_owner == o) begin
                g++;
                s_ack_i = g[0];
                m_cyc_i = N'($urandom());
            end else begin
                s_ack_i = 1'b0;
                m_cyc_i = '0;
            end
            m_cyc_i[o] = 1'b1;
            m_stb_i = m_cyc_i;
            @(negedge clk_i); model_outputs();
            checks++; if (grant_o !== exp_grant) begin errors++; $display("FAIL burst_grant: got %b expected %b", grant_o, exp_grant); end
            checks++; if (m_ack_o !== exp_ack) begin errors++; $display("FAIL burst_ack: got %b expected %b", m_ack_o, exp_ack); end
            checks++; if (s_cti_o !== exp_cti) begin errors++; $display("FAIL burst_cti: got %b expected %b", s_cti_o, exp_cti); end
            if (m_ack_o[o] === 1'b1) acks++;
            advance();
            c++;
        end
        checks++; if (acks != 4) begin errors++; $display("FAIL burst_ack_count: got %0d expected 4", acks); end
        m_cyc_i = '0; m_stb_i = '0; s_ack_i = 1'b0;
        step(); step();
    endtask

    task automatic test_reset_mid();
        m_cyc_i = 3'b001; m_stb_i = 3'b001;
        step(); step();
        m_cyc_i = '0; m_stb_i = '0;
        step(); step();
        m_cyc_i = 3'b010; m_stb_i = 3'b010;
        for (int i = 0; i < N; i++) m_cti_i[i*3 +: 3] = 3'b010;
        step(); step();
        s_ack_i = 1'b1; rst_i = 1'b1;
        @(negedge clk_i);
        checks++; if (s_cyc_o !== 1'b0 || m_ack_o !== 3'b000 || m_busy_o !== 3'b000) begin errors++; $display("FAIL rstmid_gate: got cyc %b ack %b busy %b expected 0", s_cyc_o, m_ack_o, m_busy_o); end
        advance();
        @(negedge clk_i); model_outputs();
        checks++; if (grant_o !== 3'b000 || s_cyc_o !== 1'b0) begin errors++; $display("FAIL rstmid_clear: got grant %b cyc %b expected 000 0", grant_o, s_cyc_o); end
        advance();
        rst_i = 1'b0; s_ack_i = 1'b0; m_cyc_i = 3'b111; m_stb_i = 3'b111;
        step();
        @(negedge clk_i); model_outputs();
        checks++; if (grant_o !== 3'b001) begin errors++; $display("FAIL rstmid_ptr: got %b expected 001", grant_o); end
        advance();
        m_cyc_i = '0; m_stb_i = '0;
        step(); step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(5, 0) == 0) m_cyc_i[i] = ~m_cyc_i[i];
            m_stb_i = N'($urandom());
            s_ack_i = 1'($urandom());
            rst_i   = ($urandom_range(99, 0) == 0);
            rand_buses();
            @(negedge clk_i); model_outputs();
            checks++; if (grant_o !== exp_grant) begin errors++; $display("FAIL rand_grant: got %b expected %b", grant_o, exp_grant); end
            checks++; if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o} !== {exp_cyc, exp_stb, exp_we, exp_sel}) begin errors++; $display("FAIL rand_s_ctrl: got %b expected %b", {s_cyc_o, s_stb_o, s_we_o, s_sel_o}, {exp_cyc, exp_stb, exp_we, exp_sel}); end
            checks++; if ({s_adr_o, s_dat_o, s_cti_o} !== {exp_adr, exp_dat, exp_cti}) begin errors++; $display("FAIL rand_s_bus: got %h expected %h", {s_adr_o, s_dat_o, s_cti_o}, {exp_adr, exp_dat, exp_cti}); end
            checks++; if (m_ack_o !== exp_ack) begin errors++; $display("FAIL rand_ack: got %b expected %b", m_ack_o, exp_ack); end
            checks++; if (m_busy_o !== exp_busy) begin errors++; $display("FAIL rand_busy: got %b expected %b", m_busy_o, exp_busy); end
            checks++; if (m_err_o !== exp_err) begin errors++; $display("FAIL rand_err: got %b expected %b", m_err_o, exp_err); end
            checks++; if (m_dat_o !== s_dat_i) begin errors++; $display("FAIL rand_mdat: got %h expected %h", m_dat_o, s_dat_i); end
            advance();
        end
        rst_i = 1'b0; m_cyc_i = '0; m_stb_i = '0; s_ack_i = 1'b0;
        step(); step();
    endtask

`ifdef WB_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        int err_cnt, err_cyc;
        err_cnt = 0; err_cyc = -1;
        rst_i = 1'b1; step(); rst_i = 1'b0;
        m_cyc_i = 3'b011; m_stb_i = 3'b011; s_ack_i = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i); model_outputs();
            checks++; if (m_err_o !== exp_err) begin errors++; $display("FAIL tmo_err: got %b expected %b", m_err_o, exp_err); end
            checks++; if (grant_o !== exp_grant) begin errors++; $display("FAIL tmo_grant: got %b expected %b", grant_o, exp_grant); end
            if (m_err_o[0] === 1'b1) begin err_cnt++; err_cyc = c; end
            advance();
        end
        checks++; if (err_cnt != 1 || err_cyc != 9) begin errors++; $display("FAIL tmo_pulse: got %0d pulses at cycle %0d expected 1 at 9", err_cnt, err_cyc); end
        checks++; if (grant_o !== 3'b010) begin errors++; $display("FAIL tmo_next: got %b expected 010", grant_o); end
        m_cyc_i = '0; m_stb_i = '0;
        step(); step();
    endtask
`endif

    initial begin
        rst_i = 1'b1; s_ack_i = 1'b0; s_dat_i = '0;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_sel_i = '0;
        m_adr_i = '0; m_dat_i = '0; m_cti_i = '0;
        test_reset();
        test_single();
        test_all_request();
        test_busy();
        test_burst();
        test_reset_mid();
        test_random();
`ifdef WB_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16, Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, Wishbone data width.
REQ-003 SHALL have parameter N_MASTERS, default 3, number of requesting masters (index 0..N_MASTERS-1).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, stalled-strobe limit used only when timeout is compiled in.
REQ-005 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have ports m_cyc_i, m_stb_i, m_we_i, m_sel_i  input  N_MASTERS each  per-master Wishbone control.
REQ-008 SHALL have ports m_adr_i, m_dat_i, m_cti_i  input  N_MASTERS*ADDRESS_WIDTH, N_MASTERS*DATA_WIDTH, N_MASTERS*3  packed per-master buses, master i in slice i.
REQ-009 SHALL have port m_ack_o  output  N_MASTERS  per-master ack.
REQ-010 SHALL have port m_err_o  output  N_MASTERS  per-master timeout error pulse.
REQ-011 SHALL have port m_dat_o  output  DATA_WIDTH  shared read data, equal to s_dat_i.
REQ-012 SHALL have port m_busy_o  output  N_MASTERS  bit i high when the bus is held by a master other than i.
REQ-013 SHALL have ports s_cyc_o, s_stb_o, s_we_o, s_sel_o  output  1 each  muxed slave-side control.
REQ-014 SHALL have ports s_adr_o, s_dat_o, s_cti_o  output  ADDRESS_WIDTH, DATA_WIDTH, 3  muxed slave-side buses.
REQ-015 SHALL have ports s_dat_i, s_ack_i  input  DATA_WIDTH, 1  slave read data and OR-ed slave ack.
REQ-016 SHALL have port grant_o  output  N_MASTERS  one-hot registered grant, all-zero when idle.

Function
REQ-017 SHALL implement states IDLE and OWNED; IDLE -> OWNED when any m_cyc_i is high; OWNED -> IDLE when the granted master's m_cyc_i is low, or on timeout.
REQ-018 SHALL choose the grant in IDLE round-robin, starting the search at rr_ptr and wrapping N_MASTERS-1 -> 0.
REQ-019 SHALL register the grant: a request at edge n is granted at edge n+1, so arbitration latency is one cycle.
REQ-020 SHALL set rr_ptr to (granted index + 1) mod N_MASTERS when leaving OWNED.
REQ-021 SHALL, while OWNED, drive all s_* outputs combinationally from the granted master; in IDLE, all s_* outputs are 0.
REQ-022 SHALL route s_ack_i only to the granted master's m_ack_o; other m_ack_o bits are 0.
REQ-023 SHALL hold the grant through any number of strobes and cti bursts while the owner keeps m_cyc_i high; there is no preemption.
REQ-024 SHALL insert exactly one IDLE cycle between owners, even when another master is already waiting.
REQ-025 SHALL drive m_busy_o[i] as s_cyc_o AND NOT grant_o[i].
REQ-026 SHALL ignore m_stb_i from masters whose m_cyc_i is low.

Reset
REQ-027 SHALL, on rst_i high at an edge, enter IDLE with grant_o=0, rr_ptr=0 and the timeout counter at 0; this applies mid-transfer too.
REQ-028 SHALL keep all outputs 0 while in reset: every s_* output, m_ack_o, m_err_o and m_busy_o.

Configuration
REQ-029 SHALL, with macro WB_ARBITER_TIMEOUT_EN defined, count OWNED cycles where s_stb_o is high and s_ack_i is low, and clear the count on ack or on leaving OWNED.
REQ-030 SHALL, on that count reaching TIMEOUT_CYCLES, pulse m_err_o of the owner for one cycle, drop s_cyc_o next edge, return to IDLE and advance rr_ptr.
REQ-031 SHALL, without WB_ARBITER_TIMEOUT_EN, omit the counter, tie m_err_o to 0 and hold the grant indefinitely.

Structure
REQ-032 SHALL take state encodings and the default master count from the shared globals header, alongside the existing address-map defines.
REQ-033 SHALL place round-robin selection in one combinational sub-module, wb_rr_pick (inputs: request vector and pointer; output: one-hot pick).

Verification
REQ-034 SHALL cover: master 1 alone raises cyc+stb at edge 0 -> grant_o=3'b010 at edge 1, s_adr_o equals m_adr_i slice 1, ack reaches m_ack_o[1] only.
REQ-035 SHALL cover: after reset, masters 0,1,2 request together -> grant order 0, idle, 1, idle, 2.
REQ-036 SHALL cover: master 2 owns the bus and master 0 requests -> m_busy_o=3'b011 and no grant to master 0 until master 2 drops cyc, then one idle cycle, then grant 3'b001.
REQ-037 SHALL cover: a 4-beat burst (cti=3'b010) with a slave acking every second cycle -> the grant is held, and all 4 acks go to the owner.
REQ-038 SHALL cover: rst_i asserted mid-burst -> next edge grant_o=0, s_cyc_o=0, rr_ptr=0.
REQ-039 SHALL cover, with WB_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=8: stb held with no ack -> m_err_o pulses after 8 cycles, then IDLE, then the next requester is granted.
